flame_sequencer: RTL

Explosion controller that owns the write port of the flame-map RAM inside the flame display block. It accepts bomb-explosion requests from the game logic, probes the maze map to find how far each of the four arms extends, writes flame sprite codes cell by cell, holds them for a fixed number of frames, then erases exactly the cells it wrote. After reset it sweeps the whole 32x32 flame RAM to zero so the display never shows stale flames.

---
 rtl/flame_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/flame_sequencer.sv
// rtl/flame_sequencer.sv - explosion flame sequencer owning the flame-map RAM write port
module flame_sequencer #(
    parameter int DURATION   = 30,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_X      = 24,
    parameter int MAX_Y      = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [4:0] req_x,
    input  logic [4:0] req_y,
    input  logic [2:0] req_power,
    output logic [9:0] maze_raddr,
    input  logic [2:0] maze_rdata,
    output logic [9:0] flame_ram_waddr,
    output logic [2:0] flame_ram_wdata,
    output logic       flame_ram_we,
    output logic       busy,
    output logic       burning
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [5:0] LX = 6'(MAX_X);
    localparam logic [5:0] LY = 6'(MAX_Y);
    localparam logic [7:0] DUR_LAST = 8'(DURATION - 1);

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_CENTER, S_PROBE, S_CHECK, S_NEXTDIR, S_HOLD, S_CLR_C, S_CLR_ARM
    } state_t;

    state_t          r_state;
    logic [12:0]     r_fifo [FIFO_DEPTH];
    logic [AW:0]     r_wptr, r_rptr;
    logic [9:0]      r_cnt;
    logic [4:0]      r_cx, r_cy;
    logic [2:0]      r_pow;
    logic [1:0]      r_dir;
    logic [3:0]      r_dist;
    logic [3:0][2:0] r_len;
    logic [7:0]      r_frames;
    logic            r_we, r_busy, r_burning;
    logic [9:0]      r_waddr;
    logic [2:0]      r_wdata;

    logic        w_full, w_empty, w_push, w_pop, w_oob;
    logic [12:0] w_head;
    logic [4:0]  w_nx, w_ny;
    logic [2:0]  w_arm_code;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign req_ready = !w_full && (r_state != S_INIT);
    assign w_push    = req_valid && req_ready;
    assign w_pop     = (r_state == S_IDLE) && !w_empty;
    assign w_head    = r_fifo[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr[AW-1:0]] <= {req_x, req_y, req_power};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Cell at distance r_dist from the centre along r_dir; shared by probing and clearing.
    always_comb begin
        w_nx  = r_cx;
        w_ny  = r_cy;
        w_oob = 1'b0;
        case (r_dir)
            2'd0: begin w_nx = r_cx + 5'(r_dist); w_oob = ({1'b0, r_cx} + {2'b0, r_dist}) > LX; end
            2'd1: begin w_nx = r_cx - 5'(r_dist); w_oob = {1'b0, r_dist} > r_cx; end
            2'd2: begin w_ny = r_cy + 5'(r_dist); w_oob = ({1'b0, r_cy} + {2'b0, r_dist}) > LY; end
            default: begin w_ny = r_cy - 5'(r_dist); w_oob = {1'b0, r_dist} > r_cy; end
        endcase
    end

    assign w_arm_code      = (r_dist == {1'b0, r_pow}) ? 3'd4 : (r_dir[1] ? 3'd3 : 3'd2);
    assign maze_raddr      = {w_ny, w_nx};
    assign flame_ram_we    = r_we;
    assign flame_ram_waddr = r_waddr;
    assign flame_ram_wdata = r_wdata;
    assign busy            = r_busy;
    assign burning         = r_burning;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_INIT;
            r_cnt     <= '0;
            r_cx      <= '0;
            r_cy      <= '0;
            r_pow     <= '0;
            r_dir     <= '0;
            r_dist    <= '0;
            r_len     <= '0;
            r_frames  <= '0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_busy    <= 1'b1;
            r_burning <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_we    <= 1'b1;
                    r_waddr <= r_cnt;
                    r_wdata <= 3'd0;
                    r_cnt   <= r_cnt + 10'd1;
                    if (r_cnt == 10'd1023) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    // Out-of-maze requests are popped and dropped without leaving IDLE.
                    if (!w_empty && ({1'b0, w_head[12:8]} <= LX) && ({1'b0, w_head[7:3]} <= LY)) begin
                        r_cx    <= w_head[12:8];
                        r_cy    <= w_head[7:3];
                        r_pow   <= w_head[2:0];
                        r_state <= S_CENTER;
                        r_busy  <= 1'b1;
                    end
                end
                S_CENTER: begin
                    r_we    <= 1'b1;
                    r_waddr <= {r_cy, r_cx};
                    r_wdata <= 3'd1;
                    r_dir   <= 2'd0;
                    r_dist  <= 4'd1;
                    r_len   <= '0;
                    if (r_pow == 3'd0) begin
                        r_state   <= S_HOLD;
                        r_frames  <= '0;
                        r_burning <= 1'b1;
                    end else begin
                        r_state <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    if (w_oob) begin
                        r_len[r_dir] <= 3'(r_dist - 4'd1);
                        r_state      <= S_NEXTDIR;
                    end else begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (maze_rdata != 3'd0) begin
                        r_len[r_dir] <= 3'(r_dist - 4'd1);
                        r_state      <= S_NEXTDIR;
                    end else begin
                        r_we    <= 1'b1;
                        r_waddr <= {w_ny, w_nx};
                        r_wdata <= w_arm_code;
                        if (r_dist == {1'b0, r_pow}) begin
                            r_len[r_dir] <= r_pow;
                            r_state      <= S_NEXTDIR;
                        end else begin
                            r_dist  <= r_dist + 4'd1;
                            r_state <= S_PROBE;
                        end
                    end
                end
                S_NEXTDIR: begin
                    if (r_dir == 2'd3) begin
                        r_state   <= S_HOLD;
                        r_frames  <= '0;
                        r_burning <= 1'b1;
                    end else begin
                        r_dir   <= r_dir + 2'd1;
                        r_dist  <= 4'd1;
                        r_state <= S_PROBE;
                    end
                end
                S_HOLD: begin
                    if (frame_tick) begin
                        if (r_frames == DUR_LAST) begin
                            r_state   <= S_CLR_C;
                            r_burning <= 1'b0;
                        end else begin
                            r_frames <= r_frames + 8'd1;
                        end
                    end
                end
                S_CLR_C: begin
                    r_we    <= 1'b1;
                    r_waddr <= {r_cy, r_cx};
                    r_wdata <= 3'd0;
                    r_dir   <= 2'd0;
                    r_dist  <= 4'd1;
                    r_state <= S_CLR_ARM;
                end
                S_CLR_ARM: begin
                    if (r_dist <= {1'b0, r_len[r_dir]}) begin
                        r_we    <= 1'b1;
                        r_waddr <= {w_ny, w_nx};
                        r_wdata <= 3'd0;
                        r_dist  <= r_dist + 4'd1;
                    end else if (r_dir == 2'd3) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_dir  <= r_dir + 2'd1;
                        r_dist <= 4'd1;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end
endmodule
